// File: rtl/serial_pkg.sv
// Shared serial-link types, line levels and width helpers.
// Used by the transmitter and the matching receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic line_level(
        input tx_state_t s,
        input logic      bit_val
    );
        logic lvl;
        lvl = IDLE_LEVEL;
        unique case (s)
            IDLE:  lvl = IDLE_LEVEL;
            START: lvl = START_LEVEL;
            DATA:  lvl = bit_val;
            STOP:  lvl = STOP_LEVEL;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Enable-gated bit-period counter; tick marks the last enabled cycle of a bit.
// clear restarts the period so a new frame gets a full first bit.
module baud_tick_gen
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CW = clog2_min1(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// tx is registered from the next state so the line never glitches.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int IW = clog2_min1(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             accept;
    logic             tick;

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q != IDLE);
    assign tx     = tx_q;
    assign done   = done_q;
    assign accept = valid && en && (state_q == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .clear  (accept),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = data_in;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        tx_d = line_level(state_d, shift_d[0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule
